// File: rtl/lcg_stream_checker.sv
// -----------------------------------------------------------------------------
// lcg_stream_checker
//
// Purpose
//   Consumer-side checker for the 16-bit LCG generator. It watches a stream of
//   samples and verifies that each one follows the recurrence
//   x[n+1] = (MULT*x[n] + INC) mod 2^WIDTH. The checker locks onto an
//   arbitrary stream, flags and counts sequence breaks once locked, and
//   re-acquires after an error.
//
// Optional feature (compile-time macro LCG_CHK_SEEDED_EN)
//   When defined, the checker leaves reset or clear already LOCKED, with
//   expected = SEED, so it validates the generator output from the first
//   sample onward. When undefined, it starts in IDLE and acquires lock by
//   observation.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   clear        in   synchronous clear of counters and state; beats a sample
//   in_valid     in   sample qualifier
//   in_data      in   sample value [WIDTH-1:0]
//   in_ready     out  1 whenever out of reset (the checker never stalls)
//   locked       out  high while the FSM is in LOCKED
//   mismatch     out  one-cycle pulse per failed prediction while LOCKED
//   match_count  out  saturating count of correct predictions while LOCKED
//   err_count    out  saturating count of mismatch pulses
//   expected     out  current prediction register (debug view of the FSM)
//
// Handshake: a sample is consumed on every rising edge where in_valid is high.
// in_ready is held at 1 outside reset, so valid alone qualifies the transfer;
// no backpressure is ever applied.
// -----------------------------------------------------------------------------
module lcg_stream_checker #(
   parameter int               WIDTH      = 16,
   parameter int               MULT       = 20021,
   parameter int               INC        = 1,
   parameter int               LOCK_COUNT = 4,
   parameter int               CNT_W      = 16,
   parameter logic [WIDTH-1:0] SEED       = WIDTH'(16'hACE1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             locked,
   output logic             mismatch,
   output logic [CNT_W-1:0] match_count,
   output logic [CNT_W-1:0] err_count,
   output logic [WIDTH-1:0] expected
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

`ifdef LCG_CHK_SEEDED_EN
   localparam logic SEEDED = 1'b1;
`else
   localparam logic SEEDED = 1'b0;
`endif

   // Start-up point after reset or clear: either hunting from IDLE or already
   // locked onto the generator's reset seed.
   localparam state_t           START_STATE = SEEDED ? LOCKED : IDLE;
   localparam logic [WIDTH-1:0] START_EXP   = SEEDED ? SEED : '0;

   localparam logic [WIDTH-1:0] MULT_W    = WIDTH'(MULT);
   localparam logic [WIDTH-1:0] INC_W     = WIDTH'(INC);
   // acq_cnt holds the number of matches already seen, so the match that
   // arrives while it equals LOCK_COUNT-1 is the one that completes lock.
   localparam logic [7:0]       LOCK_LAST = 8'(LOCK_COUNT - 1);

   state_t           state;
   logic [7:0]       acq_cnt;
   logic [WIDTH-1:0] next_exp;
   logic             hit;

   // The low WIDTH bits of a product depend only on the low WIDTH bits of the
   // operands, so a WIDTH-wide multiply equals the truncated 2*WIDTH product.
   function automatic logic [WIDTH-1:0] lcg_next(input logic [WIDTH-1:0] s);
      return (s * MULT_W) + INC_W;
   endfunction

   assign next_exp = lcg_next(in_data);
   assign hit      = (in_data == expected);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= START_STATE;
         in_ready    <= 1'b0;
         locked      <= SEEDED;
         mismatch    <= 1'b0;
         match_count <= '0;
         err_count   <= '0;
         expected    <= START_EXP;
         acq_cnt     <= '0;
      end else begin
         in_ready <= 1'b1;
         mismatch <= 1'b0;
         if (clear) begin
            // A sample arriving together with clear is dropped.
            state       <= START_STATE;
            locked      <= SEEDED;
            match_count <= '0;
            err_count   <= '0;
            expected    <= START_EXP;
            acq_cnt     <= '0;
         end else if (in_valid) begin
            // Every consumed sample re-seeds the prediction, hit or miss.
            expected <= next_exp;
            case (state)
               IDLE: begin
                  acq_cnt <= '0;
                  state   <= ACQUIRE;
               end
               ACQUIRE: begin
                  // Misses here are silent: the stream is not trusted yet.
                  if (hit) begin
                     acq_cnt <= acq_cnt + 8'd1;
                     if (acq_cnt == LOCK_LAST) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                     end
                  end else begin
                     acq_cnt <= '0;
                  end
               end
               LOCKED: begin
                  if (hit) begin
                     if (match_count != '1) match_count <= match_count + 1'b1;
                  end else begin
                     mismatch <= 1'b1;
                     if (err_count != '1) err_count <= err_count + 1'b1;
                     locked  <= 1'b0;
                     state   <= ACQUIRE;
                     acq_cnt <= '0;
                  end
               end
               default: begin
                  state   <= IDLE;
                  locked  <= 1'b0;
                  acq_cnt <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/lcg_stream_checker.md
Name: lcg_stream_checker

Overview:
- Consumer-side companion to the team's 16-bit LCG generator; receives a stream of samples and verifies each one follows the recurrence x[n+1] = (MULT*x[n] + INC) mod 2^WIDTH.
- Acquires lock on an arbitrary stream, flags and counts sequence breaks, and re-acquires after an error.
- Sits on the generator's output or after any link carrying its numbers, for test and health monitoring.

Parameters:
- WIDTH, 16, sample width; modulus is 2^WIDTH.
- MULT, 20021 (0x4E35), multiplier. This is the generator's 22695477 reduced mod 2^16.
- INC, 1, increment.
- LOCK_COUNT, 4, consecutive correct predictions required to declare lock (range 1..255).
- CNT_W, 16, width of the match and error counters.
- SEED, 16'hACE1, generator reset seed. Used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear: counters to 0, state to IDLE (or SEEDED start, see feature)
- in_valid  in  1  sample qualifier
- in_data  in  WIDTH  sample
- in_ready  out  1  always 1 outside reset; checker never stalls
- locked  out  1  high while in LOCKED
- mismatch  out  1  one-cycle pulse on each sample failing prediction while LOCKED
- match_count  out  CNT_W  saturating count of correct predictions in LOCKED
- err_count  out  CNT_W  saturating count of mismatch pulses
- expected  out  WIDTH  current prediction register (debug)

Behaviour:
- Reset values (rst_n low): state IDLE, in_ready 0, locked 0, mismatch 0, counters 0, expected 0, acq_cnt 0.
- A sample is consumed when in_valid is high on a clock edge. in_valid low means no state change, and the mismatch pulse is cleared.
- Prediction arithmetic: next = low WIDTH bits of (MULT*sample + INC). Full product width is 2*WIDTH; truncate, no overflow flag.
- Latency: all outputs are registered. The response to a sample at edge n is visible after edge n.
- IDLE: on sample, expected <= next(sample), acq_cnt <= 0, go to ACQUIRE.
- ACQUIRE, sample == expected: acq_cnt++. When acq_cnt reaches LOCK_COUNT, go to LOCKED and set locked = 1. expected <= next(sample) in all cases.
- ACQUIRE, sample != expected: reseed with expected <= next(sample) and acq_cnt <= 0. No mismatch pulse and no err_count change. Acquisition errors are not reported.
- LOCKED, match: match_count++ (saturating at all-ones), expected <= next(sample).
- LOCKED, mismatch: mismatch = 1 for one cycle, err_count++ (saturating), locked = 0, state ACQUIRE, expected <= next(sample), acq_cnt <= 0.
- Samples that lock the checker are not added to match_count.
- clear takes priority over a simultaneous sample; that sample is discarded.
- Reset mid-stream: everything returns to reset values immediately; no partial outputs.
- Wrap-around: samples 0 and 0xFFFF are handled with no special case. For example, next(0xFFFF) = (0xFFFF*0x4E35 + 1) mod 2^16 = 0xB1CC.

Optional Feature:
- Macro: LCG_CHK_SEEDED_EN.
- Defined: after reset or clear, state is LOCKED, locked = 1 and expected = SEED. The first sample must equal SEED exactly, so the checker validates the stream from reset onward. A mismatch on the first sample pulses mismatch and enters ACQUIRE.
- Not defined: start in IDLE as above.

Test Plan:
- Default build; after reset feed 0xACE1, 0x5896, 0x0B0F, then 3 further generator values -> locked rises after the 5th sample, mismatch never pulses, match_count = 1 after the 6th, err_count = 0.
- Locked stream at 0x0B0F expected; inject 0x1234 -> mismatch pulses one cycle, locked = 0, err_count = 1. Then feed next(0x1234) and 3 more correct samples -> locked returns.
- Random garbage in IDLE/ACQUIRE for 50 samples -> locked stays 0, err_count stays 0.
- Gaps: lock on the stream with in_valid toggling every other cycle -> same lock point as the gap-free case, no spurious mismatch. Check in_ready = 1 throughout and 0 during reset.
- Assert rst_n low mid-lock, and separately assert clear with in_valid high -> all outputs at reset values on the following cycle; the sample is ignored.
- LCG_CHK_SEEDED_EN defined; first sample 0xACE1 then 0x5896 -> locked = 1 from reset, match_count = 2. In a separate run, first sample 0x0000 -> mismatch pulse, err_count = 1, locked = 0.
